// File: rtl/sda_kernel_control_regs_pkg.sv
// Shared register offsets, CTRL bit positions and sequencer state encoding
// for the kernel control register block.
package sda_ctrl_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_GIE    = 8'h04;
    localparam logic [7:0] REG_IER    = 8'h08;
    localparam logic [7:0] REG_ISR    = 8'h0C;
    localparam logic [7:0] REG_PBB_LO = 8'h10;
    localparam logic [7:0] REG_PBB_HI = 8'h14;

    localparam int CTRL_AP_START = 0;
    localparam int CTRL_AP_DONE  = 1;
    localparam int CTRL_AP_IDLE  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GO        = 2'd1,
        WAIT_DONE = 2'd2,
        DONE_ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/sda_kernel_control_regs_if.sv
// AXI-Lite control bus between the host (master) and the register block (slave).
// Handshake: a beat transfers on a rising clk edge where both valid and ready are
// high; valid, once raised, holds with stable payload until that transfer.
interface sda_kernel_control_regs_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/sda_kernel_control_regs_axil.sv
// AXI-Lite handshake engine that turns bus beats into single-cycle register-file
// write/read strobes; read data is captured at address accept and held until rready.
module sda_axil_slave_if #(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    sda_kernel_control_regs_if.slave axi,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic [3:0]           wr_strb,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [31:0]          rd_data,
    output logic                 rd_ack,
    output logic [ADDR_BITS-1:0] rd_ack_addr
);
    logic                 wr_accept;
    logic                 rd_accept;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic                 unused_addr_bits;

    // Address and data are only taken together, so awvalid alone never sees ready.
    assign wr_accept   = axi.awvalid & axi.wvalid & ~axi.bvalid;
    assign rd_accept   = axi.arvalid & ~axi.rvalid;

    assign axi.awready = wr_accept;
    assign axi.wready  = wr_accept;
    assign axi.arready = rd_accept;
    assign axi.bresp   = 2'b00;
    assign axi.rresp   = 2'b00;

    assign wr_en       = wr_accept;
    assign wr_addr     = axi.awaddr[ADDR_BITS-1:0];
    assign wr_data     = axi.wdata;
    assign wr_strb     = axi.wstrb;
    assign rd_en       = rd_accept;
    assign rd_addr     = axi.araddr[ADDR_BITS-1:0];
    assign rd_ack      = axi.rvalid & axi.rready;
    assign rd_ack_addr = rd_addr_q;

    assign unused_addr_bits = ^{axi.araddr[31:ADDR_BITS], axi.awaddr[31:ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (reset) begin
            axi.bvalid <= 1'b0;
            axi.rvalid <= 1'b0;
            axi.rdata  <= '0;
            rd_addr_q  <= '0;
        end else begin
            if (wr_accept)
                axi.bvalid <= 1'b1;
            else if (axi.bready)
                axi.bvalid <= 1'b0;

            if (rd_accept) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= rd_data;
                rd_addr_q  <= rd_addr;
            end else if (axi.rready) begin
                axi.rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sda_kernel_control_regs.sv
// Host control registers plus the go/done four-phase sequencer that starts the
// action and collects its completion into ap_done, ISR and the interrupt line.
module sda_kernel_control_regs
    import sda_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    sda_kernel_control_regs_if.slave s_axi,
    output logic        go_0r,
    input  logic        go_0a,
    input  logic        done_0r,
    output logic        done_0a,
    output logic [63:0] param_buf_base,
    output logic        interrupt,
    output state_t      fsm_state
);
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [31:0]          rd_data;
    logic                 rd_ack;
    logic [ADDR_BITS-1:0] rd_ack_addr;

    state_t      state, state_next;
    logic        complete;
    logic        start_wr;
    logic        ap_done, gie, ier, isr;
    logic [31:0] pbb_lo, pbb_hi;

    sda_axil_slave_if #(.ADDR_BITS(ADDR_BITS)) u_axil (
        .clk         (clk),
        .reset       (reset),
        .axi         (s_axi),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ack      (rd_ack),
        .rd_ack_addr (rd_ack_addr)
    );

    assign start_wr = wr_en && (wr_addr == ADDR_BITS'(REG_CTRL)) && wr_strb[0]
                      && wr_data[CTRL_AP_START] && (state == IDLE);

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            IDLE:      if (start_wr) state_next = GO;
            GO:        if (go_0a) state_next = WAIT_DONE;
            WAIT_DONE: if (done_0r) state_next = DONE_ACK;
            DONE_ACK: begin
                if (!done_0r && !go_0a) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Handshake outputs are flopped from the next state so they never glitch on inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            go_0r   <= 1'b0;
            done_0a <= 1'b0;
        end else begin
            state   <= state_next;
            go_0r   <= (state_next == GO);
            done_0a <= (state_next == DONE_ACK);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ap_done   <= 1'b0;
            gie       <= 1'b0;
            ier       <= 1'b0;
            isr       <= 1'b0;
            pbb_lo    <= '0;
            pbb_hi    <= '0;
            interrupt <= 1'b0;
        end else begin
            if (complete)
                ap_done <= 1'b1;
            else if (rd_ack && (rd_ack_addr == ADDR_BITS'(REG_CTRL)))
                ap_done <= 1'b0;

            if (complete && ier)
                isr <= 1'b1;
            else if (wr_en && (wr_addr == ADDR_BITS'(REG_ISR)) && wr_strb[0] && wr_data[0])
                isr <= ~isr;

            if (wr_en && wr_strb[0]) begin
                if (wr_addr == ADDR_BITS'(REG_GIE)) gie <= wr_data[0];
                if (wr_addr == ADDR_BITS'(REG_IER)) ier <= wr_data[0];
            end

            for (int b = 0; b < 4; b++) begin
                if (wr_en && wr_strb[b]) begin
                    if (wr_addr == ADDR_BITS'(REG_PBB_LO)) pbb_lo[8*b +: 8] <= wr_data[8*b +: 8];
                    if (wr_addr == ADDR_BITS'(REG_PBB_HI)) pbb_hi[8*b +: 8] <= wr_data[8*b +: 8];
                end
            end

            interrupt <= gie & isr & ier;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_BITS'(REG_CTRL): begin
                rd_data[CTRL_AP_START] = (state != IDLE);
                rd_data[CTRL_AP_DONE]  = ap_done;
                rd_data[CTRL_AP_IDLE]  = (state == IDLE);
            end
            ADDR_BITS'(REG_GIE):    rd_data[0] = gie;
            ADDR_BITS'(REG_IER):    rd_data[0] = ier;
            ADDR_BITS'(REG_ISR):    rd_data[0] = isr;
            ADDR_BITS'(REG_PBB_LO): rd_data = pbb_lo;
            ADDR_BITS'(REG_PBB_HI): rd_data = pbb_hi;
            default:                rd_data = '0;
        endcase
    end

    assign param_buf_base = {pbb_hi, pbb_lo};
    assign fsm_state      = state;
endmodule

// File: tb/tb_sda_kernel_control_regs.sv
// Directed bench for the kernel control registers: AXI-Lite access, byte strobes,
// go/done sequencing against a loopback action, interrupts and mid-run reset.
module tb_sda_kernel_control_regs;
    import sda_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sda_kernel_control_regs_if s_axi ();

    logic        go_0r, go_0a, done_0r, done_0a, interrupt;
    logic [63:0] param_buf_base;
    state_t      fsm_state;

    sda_kernel_control_regs #(.ADDR_BITS(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_axi          (s_axi),
        .go_0r          (go_0r),
        .go_0a          (go_0a),
        .done_0r        (done_0r),
        .done_0a        (done_0a),
        .param_buf_base (param_buf_base),
        .interrupt      (interrupt),
        .fsm_state      (fsm_state)
    );

    // Loopback action: q follows go_0r and is dropped by done_0a; hold_done parks it.
    logic q;
    logic hold_done = 1'b0;
    assign go_0a   = q;
    assign done_0r = q & ~hold_done;
    always @(posedge clk) begin
        if (reset)        q <= 1'b0;
        else if (done_0a) q <= 1'b0;
        else if (go_0r)   q <= 1'b1;
    end

    int go_cycles = 0;
    int done_cycles = 0;
    always @(negedge clk) begin
        if (go_0r)   go_cycles++;
        if (done_0a) done_cycles++;
    end

    int errors = 0;
    int checks = 0;
    logic [1:0] last_rresp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit hs;
        s_axi.awaddr  = addr;
        s_axi.wdata   = data;
        s_axi.wstrb   = strb;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs = s_axi.awready && s_axi.wready;
            tick();
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        check("aw_w_accept", 64'(hs), 64'd1);
        s_axi.bready = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            if (s_axi.bvalid) begin
                hs = 1'b1;
                check("bresp", 64'(s_axi.bresp), 64'd0);
            end
            tick();
        end
        s_axi.bready = 1'b0;
        check("b_handshake", 64'(hs), 64'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        bit hs;
        data = '0;
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs = s_axi.arready;
            tick();
        end
        s_axi.arvalid = 1'b0;
        check("ar_accept", 64'(hs), 64'd1);
        s_axi.rready = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            if (s_axi.rvalid) begin
                hs = 1'b1;
                data = s_axi.rdata;
                last_rresp = s_axi.rresp;
            end
            tick();
        end
        s_axi.rready = 1'b0;
        check("r_handshake", 64'(hs), 64'd1);
    endtask

    task automatic wait_state(input state_t s, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (fsm_state == s);
            tick();
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          go_base, done_base, seen;
        bit          hs, found;

        s_axi.araddr = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0;
        s_axi.wstrb = '0;  s_axi.wvalid = 1'b0;  s_axi.bready = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        check("rst_go_0r", 64'(go_0r), 64'd0);
        check("rst_done_0a", 64'(done_0a), 64'd0);
        check("rst_bvalid", 64'(s_axi.bvalid), 64'd0);
        check("rst_rvalid", 64'(s_axi.rvalid), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        reset = 1'b0;
        tick();
        check("rst_pbb", param_buf_base, 64'd0);
        check("rst_irq", 64'(interrupt), 64'd0);

        axi_read(32'h0000_0000, rd);
        check("rst_ctrl", 64'(rd), 64'h4);
        check("rst_rresp", 64'(last_rresp), 64'd0);
        axi_read(32'h0000_0020, rd);
        check("unmapped_rd", 64'(rd), 64'h0);

        // Parameter buffer base, full words then a single-byte update.
        axi_write(32'(REG_PBB_LO), 32'h89AB_CDEF, 4'hF);
        axi_write(32'(REG_PBB_HI), 32'h0123_4567, 4'hF);
        check("pbb_full", param_buf_base, 64'h0123_4567_89AB_CDEF);
        axi_write(32'(REG_PBB_LO), 32'h0000_00FF, 4'h1);
        check("pbb_byte0", param_buf_base, 64'h0123_4567_89AB_CDFF);
        axi_write(32'(REG_PBB_HI), 32'hAA00_0000, 4'h8);
        check("pbb_byte7", param_buf_base, 64'hAA23_4567_89AB_CDFF);
        axi_read(32'(REG_PBB_LO), rd);
        check("pbb_lo_rd", 64'(rd), 64'h89AB_CDFF);
        axi_read(32'hFFFF_FF00 | 32'(REG_PBB_HI), rd);
        check("upper_addr_ignored", 64'(rd), 64'hAA23_4567);
        axi_write(32'h0000_0024, 32'hFFFF_FFFF, 4'hF);
        axi_read(32'h0000_0024, rd);
        check("unmapped_wr", 64'(rd), 64'h0);

        // First run with IER=0: two cycles of go_0r and of done_0a, ISR untouched.
        go_base = go_cycles;
        done_base = done_cycles;
        axi_write(32'(REG_CTRL), 32'h1, 4'h1);
        check("busy_state", 64'(fsm_state), 64'(GO));
        wait_state(IDLE, "run1_idle");
        check("run1_go_cycles", 64'(go_cycles - go_base), 64'd2);
        check("run1_done_cycles", 64'(done_cycles - done_base), 64'd2);
        axi_read(32'(REG_CTRL), rd);
        check("ctrl_done", 64'(rd), 64'h6);
        axi_read(32'(REG_CTRL), rd);
        check("ctrl_done_cleared", 64'(rd), 64'h4);
        axi_read(32'(REG_ISR), rd);
        check("isr_masked", 64'(rd), 64'h0);

        // CTRL write with wstrb[0]=0 must not start the action.
        axi_write(32'(REG_CTRL), 32'h1, 4'h2);
        tick();
        check("ctrl_strb_gated", 64'(fsm_state), 64'(IDLE));

        // awvalid alone for five cycles, then wvalid; bvalid holds until bready.
        s_axi.awaddr = 32'(REG_IER);
        s_axi.awvalid = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_axi.awready || s_axi.wready) seen++;
            tick();
        end
        check("aw_alone_ready", 64'(seen), 64'd0);
        s_axi.wdata = 32'h1;
        s_axi.wstrb = 4'h1;
        s_axi.wvalid = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs = s_axi.awready && s_axi.wready;
            tick();
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid = 1'b0;
        check("aw_late_accept", 64'(hs), 64'd1);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_axi.bvalid) seen++;
            tick();
        end
        check("bvalid_hold", 64'(seen), 64'd3);
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_axi.bvalid) seen++;
            tick();
        end
        check("bvalid_single", 64'(seen), 64'd0);
        axi_read(32'(REG_IER), rd);
        check("ier_rd", 64'(rd), 64'h1);

        // Interrupt: ISR sets at completion, interrupt follows one cycle later.
        axi_write(32'(REG_GIE), 32'h1, 4'h1);
        axi_write(32'(REG_CTRL), 32'h1, 4'h1);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            found = (fsm_state == IDLE);
            if (!found) tick();
        end
        check("run2_idle", 64'(found), 64'd1);
        check("irq_registered", 64'(interrupt), 64'd0);
        @(negedge clk);
        check("irq_rise", 64'(interrupt), 64'd1);
        tick();
        axi_read(32'(REG_ISR), rd);
        check("isr_set", 64'(rd), 64'h1);
        axi_write(32'(REG_ISR), 32'h1, 4'h1);
        tick();
        check("irq_cleared", 64'(interrupt), 64'd0);
        axi_read(32'(REG_ISR), rd);
        check("isr_toggled", 64'(rd), 64'h0);
        axi_read(32'(REG_CTRL), rd);
        check("ctrl_done_run2", 64'(rd), 64'h6);

        // Park the action in WAIT_DONE, retry start, then reset mid-run.
        hold_done = 1'b1;
        axi_write(32'(REG_CTRL), 32'h1, 4'h1);
        wait_state(WAIT_DONE, "hold_wait_done");
        axi_read(32'(REG_CTRL), rd);
        check("ctrl_busy", 64'(rd), 64'h1);
        go_base = go_cycles;
        axi_write(32'(REG_CTRL), 32'h1, 4'h1);
        repeat (3) tick();
        check("busy_start_ignored", 64'(go_cycles - go_base), 64'd0);
        check("busy_state_kept", 64'(fsm_state), 64'(WAIT_DONE));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_go_0r", 64'(go_0r), 64'd0);
        check("midrst_done_0a", 64'(done_0a), 64'd0);
        check("midrst_state", 64'(fsm_state), 64'(IDLE));
        check("midrst_pbb", param_buf_base, 64'd0);
        tick();
        reset = 1'b0;
        hold_done = 1'b0;
        tick();
        axi_read(32'(REG_CTRL), rd);
        check("midrst_ctrl", 64'(rd), 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sda_kernel_control_regs.md
Name: sda_kernel_control_regs

Overview:
- Host-facing AXI-Lite control slave and kernel start/done sequencer; sits directly upstream of teak_action_top.
- Decodes host register accesses: ap_start/ap_done/ap_idle, interrupt enables/status, 64-bit parameter buffer base.
- Drives the action's go_0r and done_0a four-phase handshake and supplies param_buf_base.

Parameters:
- ADDR_BITS, 6, low s_axi address bits decoded; upper bits ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_axi_araddr  in  32  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address accept
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, always 2'b00
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data accept
- s_axi_awaddr  in  32  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address accept
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data accept
- s_axi_bresp  out  2  write response, always 2'b00
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response accept
- go_0r  out  1  action start request
- go_0a  in  1  action start acknowledge
- done_0r  in  1  action completion request
- done_0a  out  1  action completion acknowledge
- param_buf_base  out  64  parameter buffer base address
- interrupt  out  1  level interrupt to host

Behaviour:
- Reset:
  - All outputs 0; FSM = IDLE.
  - All registers 0; CTRL reads 0x4 (idle).
- Register map (byte offsets):
  - 0x00 CTRL: bit0 ap_start, bit1 ap_done, bit2 ap_idle.
  - 0x04 GIE: bit0.
  - 0x08 IER: bit0.
  - 0x0C ISR: bit0.
  - 0x10 PBB_LO.
  - 0x14 PBB_HI.
  - Other offsets read 0; writes to them ignored, OKAY response.
- Write channel:
  - awready and wready both pulse together for exactly one cycle, only when awvalid and wvalid are both high and bvalid is low.
  - The register update takes effect at that pulse. bvalid rises the next cycle and holds until bready.
  - awvalid alone is never accepted.
- Read channel:
  - arready pulses one cycle when arvalid is high and rvalid is low.
  - rdata is registered; rvalid rises the next cycle and holds, with stable data, until rready.
- Strobes:
  - PBB_LO/PBB_HI honour per-byte wstrb.
  - CTRL/GIE/IER/ISR act only when wstrb[0]=1.
- CTRL behaviour:
  - ap_start: writing bit0=1 while FSM=IDLE sets start. Reads 1 whenever FSM≠IDLE. Writes while busy are ignored.
  - ap_done: set on the DONE_ACK→IDLE transition. Cleared at the rvalid&rready handshake of a CTRL read, which returns 1. A simultaneous set wins.
  - ap_idle = (FSM==IDLE).
- ISR/interrupt:
  - ISR bit0 is set on completion when IER[0]=1.
  - Writing 1 to ISR bit0 toggles it; a simultaneous set wins.
  - interrupt = GIE & ISR[0] & IER[0], registered.
- Sequencer FSM:
  - IDLE: go_0r=0, done_0a=0; a start write → GO next cycle.
  - GO: go_0r=1; go_0a=1 → WAIT_DONE.
  - WAIT_DONE: go_0r=0; done_0r=1 → DONE_ACK (done_0r may already be high on entry).
  - DONE_ACK: done_0a=1; done_0r=0 and go_0a=0 → IDLE, setting ap_done and the ISR condition.
  - go_0r and done_0a are registered from state, never combinational from inputs.
  - Tolerates an action that holds go_0a high until done_0a, with go_0a==done_0r.
- param_buf_base = {PBB_HI, PBB_LO}, updated the cycle after the accepting write; stable while the action runs.
- Reset mid-operation: FSM→IDLE; go_0r/done_0a drop at the next edge; pending AXI responses are abandoned (bvalid/rvalid → 0).

Decomposition:
- Package sda_ctrl_pkg:
  - register offset constants (CTRL, GIE, IER, ISR, PBB_LO, PBB_HI);
  - CTRL bit indices;
  - FSM state enum {IDLE, GO, WAIT_DONE, DONE_ACK}.
- One natural sub-module: sda_axil_slave_if, the AXI-Lite handshake plus a register-file access strobe interface (wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr, rd_data).
- The sequencer and registers stay in the top.

Test Plan:
- Reset, read 0x00 → rdata=0x00000004, rresp=0. Read 0x20 → 0.
- Write 0x10=0x89ABCDEF and 0x14=0x01234567, wstrb=0xF → param_buf_base=0x0123456789ABCDEF. Then write 0x10=0x000000FF, wstrb=0x1 → 0x01234567_89ABCDFF.
- awvalid held 5 cycles before wvalid → no awready until both are valid; a single bvalid follows.
- Loopback action model (go_0a=done_0r=q; q set by go_0r, cleared by done_0a):
  - write CTRL=1 → go_0r high until go_0a, then done_0a pulses, FSM returns IDLE;
  - CTRL reads 0x6, then 0x4.
- GIE=1, IER=1, run once → interrupt=1 one cycle after completion. Write ISR=1 → interrupt=0.
- Write CTRL=1 in WAIT_DONE → ignored, no second go_0r. Assert reset in WAIT_DONE → go_0r=0, done_0a=0, CTRL=0x4.
